// File: rtl/dadda_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dadda_pkg
//  Brief    : Shared constants, state encoding and carry-save helper for the
//             dadda multiplier and the streaming dot-product engine.
//  Revision : 1.0 - initial release
// ============================================================================
package dadda_pkg;

  // Default accumulator width: 24 bits hold 255 products of 255*255.
  localparam int ACC_W_DEF = 24;
  // Default vector-length field width: 0..255 pairs per operation.
  localparam int LEN_W_DEF = 8;

  // Engine state encoding.
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  // 3:2 carry-save compressor over whole 16-bit rows. The carry row is
  // pre-shifted into its column weight; bit 15 carries are dropped because
  // an 8x8 product never exceeds 16 bits.
  function automatic void csa(input  logic [15:0] x,
                              input  logic [15:0] y,
                              input  logic [15:0] z,
                              output logic [15:0] s,
                              output logic [15:0] c);
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

endpackage : dadda_pkg
`default_nettype wire

// File: rtl/dadda.sv
`default_nettype none
// ============================================================================
//  Module   : dadda
//  Brief    : Unsigned 8x8 multiplier with a Dadda-height reduction schedule
//             (8 -> 6 -> 4 -> 3 -> 2 rows) and a registered 16-bit product.
//             The product register has no reset.
//  Revision : 1.0 - initial release
// ============================================================================
module dadda
  import dadda_pkg::*;
(
  input  logic        clk,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [15:0] pp [8];
  logic [15:0] l1 [6];
  logic [15:0] l2 [4];
  logic [15:0] l3 [3];
  logic [15:0] l4 [2];
  logic [15:0] prod_d;

  // Partial-product rows, each already shifted to its column weight.
  for (genvar i = 0; i < 8; i++) begin : g_pp
    assign pp[i] = 16'(a & {8{b[i]}}) << i;
  end

  // Row reduction down to two rows, then a single carry-propagate add.
  always_comb begin
    // 8 -> 6 rows
    csa(pp[0], pp[1], pp[2], l1[0], l1[1]);
    csa(pp[3], pp[4], pp[5], l1[2], l1[3]);
    l1[4] = pp[6];
    l1[5] = pp[7];
    // 6 -> 4 rows
    csa(l1[0], l1[1], l1[2], l2[0], l2[1]);
    csa(l1[3], l1[4], l1[5], l2[2], l2[3]);
    // 4 -> 3 rows
    csa(l2[0], l2[1], l2[2], l3[0], l3[1]);
    l3[2] = l2[3];
    // 3 -> 2 rows
    csa(l3[0], l3[1], l3[2], l4[0], l4[1]);
    prod_d = l4[0] + l4[1];
  end

  // Product register, updated every cycle regardless of operand validity.
  always_ff @(posedge clk) begin
    p <= prod_d;
  end

endmodule : dadda
`default_nettype wire

// File: rtl/dadda_dot_acc.sv
`default_nettype none
// ============================================================================
//  Module   : dadda_dot_acc
//  Brief    : Streaming dot-product engine. Accepts LEN operand pairs over a
//             valid/ready stream, multiplies each pair in the registered dadda
//             multiplier and sums the products into an ACC_W-bit accumulator.
//             The result is presented on a valid/ready port with a sticky
//             overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module dadda_dot_acc
  import dadda_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic               ovf_q,   ovf_d;
  logic [LEN_W-1:0]   cnt_q,   cnt_d;
  logic [LEN_W-1:0]   len_q,   len_d;
  logic               p_vld_q, p_vld_d;

  logic [15:0]        prod;
  logic [ACC_W:0]     sum_ext;
  logic               hs;

  // Multiplier fed straight from the input stream; its product appears one
  // cycle later, tracked by p_vld.
  dadda u_mul (
    .clk (clk),
    .a   (in_a),
    .b   (in_b),
    .p   (prod)
  );

  assign in_ready  = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign out_sum   = out_valid ? acc_q : '0;
  assign out_ovf   = out_valid & ovf_q;
  assign busy      = (state_q != S_IDLE);

  // Next-state, counter and accumulator update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    hs      = in_valid && (state_q == S_RUN);
    p_vld_d = hs;
    sum_ext = {1'b0, acc_q} + (ACC_W+1)'(prod);

    // Only products that came from an accepted pair are summed.
    if (p_vld_q) begin
      acc_d = sum_ext[ACC_W-1:0];
      if (sum_ext[ACC_W]) begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          len_d   = len;
          state_d = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (hs) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      p_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      p_vld_q <= p_vld_d;
    end
  end

endmodule : dadda_dot_acc
`default_nettype wire

// File: tb/tb_dadda_dot_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dadda_dot_acc
//  Brief    : Directed self-checking bench for dadda_dot_acc. Two instances
//             share one stimulus stream: the default 24-bit accumulator and a
//             17-bit one used for the overflow case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dadda_dot_acc;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_ready;

  logic        in_ready,   in_ready17;
  logic        out_valid,  out_valid17;
  logic [23:0] out_sum;
  logic [16:0] out_sum17;
  logic        out_ovf,    out_ovf17;
  logic        busy,       busy17;

  int checks   = 0;
  int failures = 0;

  dadda_dot_acc #(.ACC_W(24), .LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  dadda_dot_acc #(.ACC_W(17), .LEN_W(8)) dut17 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready17),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid17),
    .out_ready (out_ready),
    .out_sum   (out_sum17),
    .out_ovf   (out_ovf17),
    .busy      (busy17)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
    len   = 8'd0;
  endtask

  task automatic feed(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Idle cycle with random operands so the multiplier holds a garbage product.
  task automatic gap();
    in_valid = 1'b0;
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
    tick();
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk(tag, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
    in_a = 8'd0; in_b = 8'd0; out_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum",   out_sum,   0);
    chk("rst_out_ovf",   out_ovf,   0);
    chk("rst_busy",      busy,      0);
    rst = 1'b0;
    tick();

    // 1: basic sum, back-to-back pairs
    do_start(8'd3);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_busy",     busy,     1);
    feed(8'd2, 8'd3); feed(8'd4, 8'd5); feed(8'd255, 8'd255);
    chk("t1_drain_ready", in_ready,  0);
    chk("t1_drain_valid", out_valid, 0);
    tick();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_sum",   out_sum,   65051);
    chk("t1_out_ovf",   out_ovf,   0);
    consume("t1_idle_busy");

    // 2: in_valid in IDLE is ignored; len=0 completes immediately
    in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9;
    tick();
    chk("t2_idle_ready", in_ready, 0);
    chk("t2_idle_busy",  busy,     0);
    do_start(8'd0);
    chk("t2_out_valid", out_valid, 1);
    chk("t2_out_sum",   out_sum,   0);
    chk("t2_in_ready",  in_ready,  0);
    in_valid = 1'b0;
    consume("t2_idle_busy_after");

    // 3: same vectors with valid pattern 1,0,0,1,0,1
    do_start(8'd3);
    feed(8'd2, 8'd3); gap(); gap(); feed(8'd4, 8'd5); gap(); feed(8'd255, 8'd255);
    chk("t3_drain_valid", out_valid, 0);
    tick();
    chk("t3_out_valid", out_valid, 1);
    chk("t3_out_sum",   out_sum,   65051);
    consume("t3_idle_busy");

    // 4: backpressure in DONE with start pulses
    do_start(8'd1);
    feed(8'd1, 8'd2);
    tick();
    chk("t4_out_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      len   = 8'd0;
      tick();
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_sum",   out_sum,   2);
      chk("t4_hold_ready", in_ready,  0);
    end
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    chk("t4_consumed_busy",  busy,      0);
    chk("t4_consumed_valid", out_valid, 0);
    tick();
    chk("t4_start_ignored_busy", busy, 0);

    // 5: overflow in the 17-bit instance
    do_start(8'd3);
    feed(8'd255, 8'd255); feed(8'd255, 8'd255); feed(8'd255, 8'd255);
    tick();
    chk("t5_valid17", out_valid17, 1);
    chk("t5_sum17",   out_sum17,   64003);
    chk("t5_ovf17",   out_ovf17,   1);
    chk("t5_sum24",   out_sum,     195075);
    chk("t5_ovf24",   out_ovf,     0);
    consume("t5_idle_busy");
    do_start(8'd1);
    feed(8'd1, 8'd1);
    tick();
    chk("t5b_sum17", out_sum17, 1);
    chk("t5b_ovf17", out_ovf17, 0);
    consume("t5b_idle_busy");

    // 6: reset mid-operation
    do_start(8'd4);
    feed(8'd1, 8'd1); feed(8'd2, 8'd2);
    in_valid = 1'b1; in_a = 8'd3; in_b = 8'd3; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("t6_rst_in_ready",  in_ready,  0);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_out_sum",   out_sum,   0);
    chk("t6_rst_out_ovf",   out_ovf,   0);
    chk("t6_rst_busy",      busy,      0);
    do_start(8'd1);
    feed(8'd7, 8'd9);
    tick();
    chk("t6_out_valid", out_valid, 1);
    chk("t6_out_sum",   out_sum,   63);
    consume("t6_idle_busy");

    // Max case: 255 pairs of (255,255)
    do_start(8'd255);
    for (int i = 0; i < 255; i++) begin
      feed(8'd255, 8'd255);
    end
    chk("max_drain_valid", out_valid, 0);
    tick();
    chk("max_out_valid", out_valid, 1);
    chk("max_out_sum",   out_sum,   16581375);
    chk("max_out_ovf",   out_ovf,   0);
    consume("max_idle_busy");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dadda_dot_acc
`default_nettype wire
